mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single unified instruction/data memory between the multicycle CPU (port 0) and
//  a program loader/DMA engine (port 1). Grants one access at a time, holds the memory
//  interface stable for MEM_LAT cycles and returns a one-cycle ack with registered read data.
//  The CPU control FSM stalls its memory states until p0_ack.
// PARAMETERS
//  AW       32  address width, in bits
//  DW       32  data width, in bits
//  MEM_LAT  2   cycles mem_en/addr/we/wdata are held per access; must be >= 1
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   synchronous, active-high
//  p0_req     in   1   CPU request; held with its payload until p0_ack
//  p0_we      in   1   1 = write, 0 = read
//  p0_addr    in   AW  byte address
//  p0_wdata   in   DW  write data
//  p0_ack     out  1   one-cycle completion strobe
//  p0_rdata   out  DW  read data; valid in the p0_ack cycle and held until the next port-0 read completes
//  p1_*       same set as p0_*, for the loader/DMA port
//  mem_en     out  1   memory access enable
//  mem_we     out  1   memory write enable
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data; valid in the last cycle of ACCESS
//  busy       out  1   high in ACCESS and DONE
// BEHAVIOUR
//  Reset: state=IDLE; mem_en, mem_we, mem_addr, mem_wdata, p0/p1_ack, p0/p1_rdata, busy = 0;
//   rr_last=1, so port 0 wins the first tie. Reset in mid-access aborts it with no ack;
//   memory contents after an aborted write are undefined.
//  FSM IDLE -> ACCESS -> DONE -> IDLE:
//   IDLE: if any req is high, pick owner, latch we/addr/wdata, set cnt=MEM_LAT-1 -> ACCESS.
//   ACCESS: mem_en=1; mem_we=latched we; addr/wdata come from latches, stable for all
//    MEM_LAT cycles. On cnt==0, capture mem_rdata (reads only) -> DONE; otherwise cnt--.
//   DONE: owner's ack=1 for exactly one cycle; rr_last=owner -> IDLE.
//  Latency: with req first high in cycle t, state IDLE and no contention, ack is high in
//   cycle t+MEM_LAT+1. Back-to-back accesses run every MEM_LAT+2 cycles.
//  Arbitration: requests are sampled only in IDLE. If only one port requests, it wins.
//   On a tie, the port != rr_last wins (round-robin).
//  The requester may drop req, or present a new payload, in the cycle after ack.
//   A req still high during DONE is ignored until IDLE.
//  Writes do not modify pX_rdata. The non-owner port never sees ack.
//  cnt width = $clog2(MEM_LAT+1). There is no wrap: cnt reloads in IDLE only.
// CONFIGURATION
//  FIXED_PRIO_EN defined: port 0 (CPU) always wins a tie, and rr_last is unused.
//   Port 1 can starve while the CPU issues back-to-back requests.
//  FIXED_PRIO_EN undefined: round-robin as above. Each port waits at most one foreign access.
// STRUCTURE
//  mem_arb_pkg holds: state encodings (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2), port ids
//   PORT_CPU=1'b0 and PORT_DMA=1'b1, and a MEM_LAT default constant.
//  Sub-module mem_arb_pick: combinational 2-way picker with inputs (req0, req1, rr_last)
//   and output owner; it contains the FIXED_PRIO_EN switch. The FSM, latches and counter
//   stay in mem_arbiter.
// TESTING (MEM_LAT=2)
//  Single read: p0 reads 0x10, and mem returns 0xDEADBEEF.
//   -> mem_en high for 2 cycles, p0_ack 3 cycles after req, p0_rdata=0xDEADBEEF.
//  Single write: p1 writes 0x55AA55AA to 0x20.
//   -> mem_we=1 with mem_en for 2 cycles, addr 0x20 stable, p1_ack one cycle, p1_rdata unchanged.
//  Tie after reset: p0 and p1 both request in cycle 0.
//   -> p0 acked in cycle 3, p1 acked in cycle 7. Both held high: grants alternate p0, p1, p0.
//  FIXED_PRIO_EN, both ports held high for 3 accesses: -> three p0 acks, no p1_ack.
//  Reset mid-access: assert reset in the 2nd ACCESS cycle.
//   -> next cycle mem_en=0, no ack, state IDLE, rr_last=1.
//  Payload change after ack: p0 changes addr in the cycle after ack.
//   -> new access uses the new addr, and the old addr never reappears on mem_addr.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter.
//   - FSM state encodings (IDLE / ACCESS / DONE)
//   - port identifiers (CPU = port 0, loader/DMA = port 1)
//   - default access latency
//   - other_port(): the port that is not the given one
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam int MEM_LAT_DEF = 2;

  function automatic logic other_port(input logic port);
    return (port == PORT_CPU) ? PORT_DMA : PORT_CPU;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational 2-way request picker for mem_arbiter.
// Build option: FIXED_PRIO_EN -- when defined the CPU port always wins a tie
// (rr_last is ignored); when undefined a tie goes to the port that was not
// served last (round-robin).
// Ports:
//   req0    in  1  port 0 (CPU) request
//   req1    in  1  port 1 (loader/DMA) request
//   rr_last in  1  port that owned the most recently completed access
//   owner   out 1  selected port; only meaningful when req0 or req1 is high
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic rr_last,
  output logic owner
);

  always_comb begin
    owner = PORT_CPU;
    if (req1 && !req0) begin
      owner = PORT_DMA;
    end else if (req0 && req1) begin
`ifdef FIXED_PRIO_EN
      owner = PORT_CPU;
`else
      owner = other_port(rr_last);
`endif
    end
  end

`ifdef FIXED_PRIO_EN
  // Fixed priority has no use for the round-robin history.
  logic unused_rr_last;
  assign unused_rr_last = rr_last;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the unified instruction/data memory between the
// multicycle CPU (port 0) and the program loader/DMA engine (port 1).
// One access at a time: the winning request's payload is latched in IDLE,
// presented to memory for MEM_LAT cycles (ACCESS), then the owner gets a
// one-cycle ack (DONE) with read data already registered on its pX_rdata.
// Build option: FIXED_PRIO_EN (see mem_arb_pick) selects fixed CPU priority
// instead of round-robin on a tie.
// Ports:
//   clk, reset           clock (rising edge), synchronous active-high reset
//   pX_req/we/addr/wdata request from port X, held until pX_ack
//   pX_ack               one-cycle completion strobe to port X
//   pX_rdata             last read data returned to port X
//   mem_en/we/addr/wdata memory interface, driven only during ACCESS
//   mem_rdata            memory read data, sampled in the last ACCESS cycle
//   busy                 high while an access is in ACCESS or DONE
// MEM_LAT must be >= 1.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = MEM_LAT_DEF
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = $clog2(MEM_LAT + 1);

  logic [1:0]    state;
  logic          owner;
  logic          rr_last;
  logic          pick;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [CW-1:0] cnt;

  mem_arb_pick u_pick (
    .req0    (p0_req),
    .req1    (p1_req),
    .rr_last (rr_last),
    .owner   (pick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      owner    <= PORT_CPU;
      rr_last  <= PORT_DMA;   // port 0 wins the first tie
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt      <= '0;
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else begin
      case (state)
        // IDLE: sample requests, latch the winner's payload
        ST_IDLE: begin
          if (p0_req || p1_req) begin
            owner   <= pick;
            we_q    <= (pick == PORT_DMA) ? p1_we    : p0_we;
            addr_q  <= (pick == PORT_DMA) ? p1_addr  : p0_addr;
            wdata_q <= (pick == PORT_DMA) ? p1_wdata : p0_wdata;
            cnt     <= CW'(MEM_LAT - 1);
            state   <= ST_ACCESS;
          end
        end
        // ACCESS: hold the interface; read data is valid on the final cycle
        ST_ACCESS: begin
          if (cnt == '0) begin
            if (!we_q) begin
              if (owner == PORT_DMA) p1_rdata <= mem_rdata;
              else                   p0_rdata <= mem_rdata;
            end
            state <= ST_DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        // DONE: ack the owner; requests still high here wait for IDLE
        ST_DONE: begin
          rr_last <= owner;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Memory outputs are zero outside ACCESS so a stale latched address is
  // never visible while the requester is changing its payload.
  assign mem_en    = (state == ST_ACCESS);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = mem_en ? addr_q  : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;

  assign p0_ack = (state == ST_DONE) && (owner == PORT_CPU);
  assign p1_ack = (state == ST_DONE) && (owner == PORT_DMA);
  assign busy   = (state == ST_ACCESS) || (state == ST_DONE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with MEM_LAT = 2.
// A small word memory model (64 words, byte address bits [7:2]) answers
// mem_rdata combinationally and absorbs writes on the clock edge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p0_ack;
  logic        p1_req, p1_we;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic        p1_ack;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  int checks = 0;
  int passes = 0;

  logic [31:0] mem_arr [64];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;
  logic        unused_tb;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always @(posedge clk) begin
    if (pl_en) mem_arr[pl_idx] <= pl_data;
    else if (mem_en && mem_we) mem_arr[mem_addr[7:2]] <= mem_wdata;
  end
  assign mem_rdata = mem_arr[mem_addr[7:2]];
  assign unused_tb = ^{mem_addr[31:8], mem_addr[1:0]};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    pl_idx = idx; pl_data = data; pl_en = 1'b1;
    step();
    pl_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    p0_req = 0; p1_req = 0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    preload(6'd4,  32'hDEADBEEF);   // 0x10
    preload(6'd12, 32'h12345678);   // 0x30
    preload(6'd20, 32'hCAFEF00D);   // 0x50
    preload(6'd8,  32'h00000000);   // 0x20
    step();
    checks++;
    if ({mem_en, mem_we, busy} !== 3'b000)
      $display("FAIL reset_ctrl: en/we/busy=%b required 000", {mem_en, mem_we, busy});
    else passes++;
    checks++;
    if ({p0_ack, p1_ack} !== 2'b00)
      $display("FAIL reset_ack: acks=%b required 00", {p0_ack, p1_ack});
    else passes++;
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0)
      $display("FAIL reset_mem_bus: addr=%h wdata=%h required 0", mem_addr, mem_wdata);
    else passes++;
    checks++;
    if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0)
      $display("FAIL reset_rdata: p0=%h p1=%h required 0", p0_rdata, p1_rdata);
    else passes++;
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    int en_cnt = 0, bad = 0, ack_cyc = -1, ack_cnt = 0, p1a = 0;
    logic [31:0] rd_at_ack = '0;
    p0_we = 0; p0_addr = 32'h10; p0_req = 1;           // cycle 0
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 4) p0_req = 0;
      if (mem_en) begin
        en_cnt++;
        if (mem_addr !== 32'h10 || mem_we !== 1'b0) bad++;
      end
      if (p0_ack) begin ack_cnt++; ack_cyc = k; rd_at_ack = p0_rdata; end
      if (p1_ack) p1a++;
    end
    checks++;
    if (en_cnt !== 2) $display("FAIL read_en_cycles: got %0d required 2", en_cnt); else passes++;
    checks++;
    if (bad !== 0) $display("FAIL read_bus_stable: bad cycles %0d required 0", bad); else passes++;
    checks++;
    if (ack_cyc !== 3 || ack_cnt !== 1)
      $display("FAIL read_ack: cycle %0d count %0d required cycle 3 count 1", ack_cyc, ack_cnt);
    else passes++;
    checks++;
    if (rd_at_ack !== 32'hDEADBEEF)
      $display("FAIL read_data: got %h required deadbeef", rd_at_ack);
    else passes++;
    checks++;
    if (p0_rdata !== 32'hDEADBEEF || busy !== 1'b0)
      $display("FAIL read_hold: rdata %h busy %b required deadbeef 0", p0_rdata, busy);
    else passes++;
    checks++;
    if (p1a !== 0) $display("FAIL read_foreign_ack: p1 acks %0d required 0", p1a); else passes++;
  endtask

  task automatic test_single_write();
    int ack_cyc = -1, ack_cnt = 0, good = 0, bad = 0, p0a = 0;
    // p1 read first so that p1_rdata holds a known non-zero value
    p1_we = 0; p1_addr = 32'h30; p1_req = 1;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 4) p1_req = 0;
      if (p1_ack) ack_cyc = k;
    end
    checks++;
    if (ack_cyc !== 3 || p1_rdata !== 32'h12345678)
      $display("FAIL dma_read: ack cycle %0d rdata %h required 3 12345678", ack_cyc, p1_rdata);
    else passes++;
    ack_cyc = -1;
    p1_we = 1; p1_addr = 32'h20; p1_wdata = 32'h55AA55AA; p1_req = 1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 4) begin p1_req = 0; p1_we = 0; end
      if (mem_en) begin
        if (mem_we === 1'b1 && mem_addr === 32'h20 && mem_wdata === 32'h55AA55AA) good++;
        else bad++;
      end
      if (p1_ack) begin ack_cnt++; ack_cyc = k; end
      if (p0_ack) p0a++;
    end
    checks++;
    if (good !== 2 || bad !== 0)
      $display("FAIL write_bus: good %0d bad %0d required 2 0", good, bad);
    else passes++;
    checks++;
    if (ack_cyc !== 3 || ack_cnt !== 1)
      $display("FAIL write_ack: cycle %0d count %0d required cycle 3 count 1", ack_cyc, ack_cnt);
    else passes++;
    checks++;
    if (p1_rdata !== 32'h12345678)
      $display("FAIL write_rdata_kept: got %h required 12345678", p1_rdata);
    else passes++;
    checks++;
    if (mem_arr[8] !== 32'h55AA55AA)
      $display("FAIL write_mem: got %h required 55aa55aa", mem_arr[8]);
    else passes++;
    checks++;
    if (p0a !== 0) $display("FAIL write_foreign_ack: p0 acks %0d required 0", p0a); else passes++;
  endtask

  task automatic test_tie();
    int p0_n = 0, p1_n = 0, both = 0;
    int p0_first = -1, p0_second = -1, p1_first = -1;
    do_reset();
    p0_we = 0; p0_addr = 32'h10; p0_req = 1;            // cycle 0
    p1_we = 0; p1_addr = 32'h30; p1_req = 1;
    for (int k = 1; k <= 13; k++) begin
      step();
      if (k == 12) begin p0_req = 0; p1_req = 0; end
      if (p0_ack && p1_ack) both++;
      if (p0_ack) begin
        if (p0_n == 0) p0_first = k;
        else if (p0_n == 1) p0_second = k;
        p0_n++;
      end
      if (p1_ack) begin
        if (p1_n == 0) p1_first = k;
        p1_n++;
      end
    end
    checks++;
    if (p0_first !== 3) $display("FAIL tie_first_p0: cycle %0d required 3", p0_first); else passes++;
    checks++;
    if (both !== 0) $display("FAIL tie_exclusive: dual acks %0d required 0", both); else passes++;
`ifdef FIXED_PRIO_EN
    checks++;
    if (p0_n !== 3 || p1_n !== 0)
      $display("FAIL prio_counts: p0 %0d p1 %0d required 3 0", p0_n, p1_n);
    else passes++;
    checks++;
    if (p0_second !== 7) $display("FAIL prio_second_p0: cycle %0d required 7", p0_second); else passes++;
`else
    checks++;
    if (p0_n !== 2 || p1_n !== 1)
      $display("FAIL rr_counts: p0 %0d p1 %0d required 2 1", p0_n, p1_n);
    else passes++;
    checks++;
    if (p1_first !== 7 || p0_second !== 11)
      $display("FAIL rr_order: p1 at %0d p0 at %0d required 7 11", p1_first, p0_second);
    else passes++;
    checks++;
    if (p1_rdata !== 32'h12345678)
      $display("FAIL rr_p1_data: got %h required 12345678", p1_rdata);
    else passes++;
`endif
  endtask

  task automatic test_reset_mid();
    int acks = 0, p0_first = -1, p1_first = -1;
    // previous test left rr_last = port 0 in round-robin mode
    p0_we = 0; p0_addr = 32'h30; p0_req = 1;            // cycle 0
    step(); step();                                      // cycle 2: 2nd ACCESS cycle
    checks++;
    if (mem_en !== 1'b1) $display("FAIL mid_precond: mem_en %b required 1", mem_en); else passes++;
    reset = 1'b1; p0_req = 0;
    step();                                              // cycle 3
    reset = 1'b0;
    checks++;
    if ({mem_en, busy, p0_ack, p1_ack} !== 4'b0000)
      $display("FAIL mid_abort: en/busy/acks %b required 0000", {mem_en, busy, p0_ack, p1_ack});
    else passes++;
    for (int k = 4; k <= 6; k++) begin
      step();
      if (p0_ack || p1_ack || mem_en) acks++;
    end
    checks++;
    if (acks !== 0) $display("FAIL mid_quiet: activity cycles %0d required 0", acks); else passes++;
    checks++;
    if (p0_rdata !== 32'h0) $display("FAIL mid_rdata: got %h required 0", p0_rdata); else passes++;
    // rr_last must be back to port 1, so port 0 wins this tie
    p0_addr = 32'h10; p0_req = 1; p1_addr = 32'h30; p1_req = 1;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 4) begin p0_req = 0; p1_req = 0; end
      if (p0_ack && p0_first < 0) p0_first = k;
      if (p1_ack && p1_first < 0) p1_first = k;
    end
    checks++;
    if (p0_first !== 3 || p1_first !== -1)
      $display("FAIL mid_rr_reset: p0 ack %0d p1 ack %0d required 3 -1", p0_first, p1_first);
    else passes++;
  endtask

  task automatic test_payload_change();
    int old_seen = 0, new_en = 0, old_en = 0, n = 0, a1 = -1, a2 = -1;
    step(); step();                                      // let the tie test drain to IDLE
    p0_we = 0; p0_addr = 32'h10; p0_req = 1;            // cycle 0
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 4) p0_addr = 32'h50;
      if (k == 8) p0_req = 0;
      if (k <= 3 && mem_en && mem_addr === 32'h10) old_en++;
      if (k >= 4 && mem_addr === 32'h10) old_seen++;
      if (mem_en && mem_addr === 32'h50) new_en++;
      if (p0_ack) begin
        if (n == 0) a1 = k; else a2 = k;
        n++;
      end
    end
    checks++;
    if (old_en !== 2 || new_en !== 2)
      $display("FAIL payload_addrs: old %0d new %0d required 2 2", old_en, new_en);
    else passes++;
    checks++;
    if (old_seen !== 0) $display("FAIL payload_stale: old addr cycles %0d required 0", old_seen); else passes++;
    checks++;
    if (a1 !== 3 || a2 !== 7 || n !== 2)
      $display("FAIL payload_acks: %0d %0d n=%0d required 3 7 n=2", a1, a2, n);
    else passes++;
    checks++;
    if (p0_rdata !== 32'hCAFEF00D)
      $display("FAIL payload_data: got %h required cafef00d", p0_rdata);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_tie();
    test_reset_mid();
    test_payload_change();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
